// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller
// Optional load hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 2,
  parameter int LINES         = 3,
  parameter int FILL_LATENCY  = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cpu_req,
  input  logic                                        cpu_we,
  input  logic [ADDRESS_WIDTH-1:0]                    cpu_addr,
  input  logic [DATA_WIDTH-1:0]                       cpu_wdata,
  output logic [DATA_WIDTH-1:0]                       cpu_rdata,
  output logic                                        cpu_stall,
  output logic [ADDRESS_WIDTH-1:0]                    mem_address,
  output logic [DATA_WIDTH-1:0]                       mem_write_data,
  output logic                                        mem_write_enable,
  input  logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0]       mem_read_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                                 hit_count,
  output logic [31:0]                                 miss_count
`endif
);

  localparam int WPB   = 2**BLOCK_SIZE;
  localparam int NL    = 2**LINES;
  localparam int TAG_W = ADDRESS_WIDTH - BLOCK_SIZE - LINES;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_n;
  logic [3:0]            fill_cnt_q, fill_cnt_n;
  logic [NL-1:0]         valid_q;
  logic [TAG_W-1:0]      tag_q  [NL];
  logic [DATA_WIDTH-1:0] data_q [NL][WPB];

  logic [BLOCK_SIZE-1:0] off;
  logic [LINES-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  store_hit;
  logic                  fill_done;

  assign off = cpu_addr[BLOCK_SIZE-1:0];
  assign idx = cpu_addr[BLOCK_SIZE+LINES-1:BLOCK_SIZE];
  assign tag = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_n          = state_q;
    fill_cnt_n       = fill_cnt_q;
    cpu_stall        = 1'b0;
    cpu_rdata        = '0;
    mem_address      = cpu_addr;
    mem_write_data   = cpu_wdata;
    mem_write_enable = 1'b0;
    store_hit        = 1'b0;
    fill_done        = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              // write-through: memory always sees the store, cache only on hit
              mem_write_enable = 1'b1;
              store_hit        = hit;
            end else if (hit) begin
              cpu_rdata = data_q[idx][off];
            end else begin
              cpu_stall  = 1'b1;
              state_n    = FILL;
              fill_cnt_n = '0;
            end
          end
        end
        FILL: begin
          cpu_stall   = 1'b1;
          mem_address = {cpu_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
          if (fill_cnt_q == 4'(FILL_LATENCY - 1)) begin
            fill_done  = 1'b1;
            fill_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            fill_cnt_n = fill_cnt_q + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_n;
      fill_cnt_q <= fill_cnt_n;
      if (fill_done) begin
        // lines are never dirty, so a conflicting fill simply overwrites
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
        for (int w = 0; w < WPB; w++) begin
          data_q[idx][w] <= mem_read_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (store_hit) begin
        data_q[idx][off] <= cpu_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic stat_hit;
  logic stat_miss;

  assign stat_hit  = !rst && (state_q == IDLE) && cpu_req && !cpu_we && hit;
  assign stat_miss = !rst && (state_q == IDLE) && cpu_req && !cpu_we && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (stat_hit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (stat_miss && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
